// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer (package instr_seq_pkg).
package instr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    ERROR,
    PAUSE
  } state_t;

  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_GCD  = 4'h3;
  localparam logic [3:0] OPC_HALT = 4'hB;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OPC  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  function automatic logic is_valid_opc(input logic [3:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_GCD);
  endfunction

endpackage

// File: rtl/instr_sequencer_watchdog.sv
// Datapath timeout counter: expired flags the TIMEOUT-th enabled cycle since the last clear.
module instr_seq_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetch/decode/execute loop driving the ALU/GCD datapath.
// Optional single-step mode (step port, PAUSE state): define INSTR_SEQUENCER_SINGLE_STEP_EN.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned OPC_W   = 4,
  parameter  int unsigned ADDR_W  = 5,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned INSTR_W = OPC_W + 2 * DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [INSTR_W-1:0] instr,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  pc,
  input  logic               done,
  output logic               enable,
  output logic [OPC_W-1:0]   opcode,
  output logic [DATA_W-1:0]  a,
  output logic [DATA_W-1:0]  b,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code
);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [OPC_W-1:0]    opcode_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                mem_rd_q, enable_q, halted_q, error_q;
  logic [1:0]          err_code_q;

  logic [OPC_W-1:0]    instr_opc;
  logic [DATA_W-1:0]   instr_a, instr_b;
  logic                opc_valid, opc_halt, expired;

  assign instr_opc = instr[INSTR_W-1 -: OPC_W];
  assign instr_a   = instr[2*DATA_W-1 -: DATA_W];
  assign instr_b   = instr[DATA_W-1:0];
  // Opcodes wider than 4 bits are only valid when the upper bits are zero.
  assign opc_valid = is_valid_opc(instr_opc[3:0]) && ((instr_opc >> 4) == '0);
  assign opc_halt  = (instr_opc == OPC_W'(OPC_HALT));

  instr_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == DECODE),
    .en      (state_q == EXECUTE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      opcode_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mem_rd_q   <= 1'b0;
      enable_q   <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      mem_rd_q <= 1'b0;
      halted_q <= 1'b0;
      case (state_q)
        IDLE, ERROR: begin
          if (go) begin
            pc_q       <= start_addr;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            mem_rd_q   <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          opcode_q <= instr_opc;
          a_q      <= instr_a;
          b_q      <= instr_b;
          if (opc_halt) begin
            halted_q <= 1'b1;
            state_q  <= IDLE;
          end else if (opc_valid) begin
            enable_q <= 1'b1;
            state_q  <= EXECUTE;
          end else begin
            error_q    <= 1'b1;
            err_code_q <= ERR_OPC;
            state_q    <= ERROR;
          end
        end
        EXECUTE: begin
          if (done) begin
            enable_q <= 1'b0;
            if (pc_q == '1) begin
              pc_q     <= '0;
              halted_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              pc_q <= pc_q + 1'b1;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
              state_q <= PAUSE;
`else
              mem_rd_q <= 1'b1;
              state_q  <= FETCH;
`endif
            end
          end else if (expired) begin
            enable_q   <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= ERROR;
          end
        end
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        PAUSE: begin
          if (step) begin
            mem_rd_q <= 1'b1;
            state_q  <= FETCH;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd   = mem_rd_q;
  assign pc       = pc_q;
  assign enable   = enable_q;
  assign opcode   = opcode_q;
  assign a        = a_q;
  assign b        = b_q;
  assign busy     = (state_q != IDLE) && (state_q != ERROR);
  assign halted   = halted_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (ADDR_W=3, TIMEOUT=10).
module tb_instr_sequencer;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned INSTR_W = OPC_W + 2 * DATA_W;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  localparam int PAUSE_LAT = 1;
`else
  localparam int PAUSE_LAT = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               go = 1'b0;
  logic [ADDR_W-1:0]  start_addr = '0;
  logic [INSTR_W-1:0] instr = '0;
  logic               done = 1'b0;
  logic               mem_rd, enable, busy, halted, error;
  logic [ADDR_W-1:0]  pc;
  logic [OPC_W-1:0]   opcode;
  logic [DATA_W-1:0]  a, b;
  logic [1:0]         err_code;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic               step = 1'b1;
`endif

  logic [INSTR_W-1:0] mem [8];
  int errs = 0, checks = 0;
  int dlat = 2;
  int ecnt = 0, en_cyc = 0, halt_cnt = 0, rd_cnt = 0;

  instr_sequencer #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    .step      (step),
`endif
    .start_addr(start_addr),
    .instr     (instr),
    .mem_rd    (mem_rd),
    .pc        (pc),
    .done      (done),
    .enable    (enable),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .halted    (halted),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Registered program memory: data valid the cycle after mem_rd.
  always @(posedge clk) if (mem_rd) instr <= mem[pc];

  // Datapath stand-in: done on the dlat-th enabled cycle (dlat=0 never answers); also monitors.
  always @(negedge clk) begin
    if (enable) begin
      ecnt   = ecnt + 1;
      en_cyc = en_cyc + 1;
    end else begin
      ecnt = 0;
    end
    done = (dlat != 0) && enable && (ecnt == dlat);
    if (halted) halt_cnt = halt_cnt + 1;
    if (mem_rd) rd_cnt = rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input logic [ADDR_W-1:0] addr);
    go = 1'b1;
    start_addr = addr;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    tick();
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!enable && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_en"}, {31'b0, enable}, 32'd1);
  endtask

  int h0, e0, r0, bad;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 20'h1_05_03;
    mem[1] = 20'h3_0C_08;
    mem[2] = 20'hB_00_00;
    mem[4] = 20'h7_AA_55;
    mem[5] = 20'h2_10_20;
    mem[6] = 20'hB_00_00;
    mem[7] = 20'h1_01_02;

    repeat (3) tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_opc_ab", {8'b0, 4'(opcode), a, b}, 32'd0);
    chk("rst_strobes", {29'b0, mem_rd, enable, halted}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {29'b0, error, err_code}, 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();

    // Normal run: ADD, GCD, HALT from address 0
    h0 = halt_cnt; e0 = en_cyc;
    pulse_go(3'd0);
    chk("run_fetch", {30'b0, mem_rd, busy}, 32'd3);
    chk("run_fetch_pc", 32'(pc), 32'd0);
    tick();
    chk("run_decode_rd", {31'b0, mem_rd}, 32'd0);
    chk("run_decode_en", {31'b0, enable}, 32'd0);
    tick();
    chk("run_exec0_en", {31'b0, enable}, 32'd1);
    chk("run_exec0_fields", {12'b0, 4'(opcode), a, b}, 32'h1_05_03);
    tick(); tick();
    repeat (PAUSE_LAT) tick();
    chk("run_fetch1", {29'b0, mem_rd, enable, busy}, 32'd5);
    chk("run_fetch1_pc", 32'(pc), 32'd1);
    tick(); tick();
    chk("run_exec1_en", {31'b0, enable}, 32'd1);
    chk("run_exec1_fields", {12'b0, 4'(opcode), a, b}, 32'h3_0C_08);
    wait_idle("run");
    chk("run_halted", 32'(halt_cnt - h0), 32'd1);
    chk("run_pc", 32'(pc), 32'd2);
    chk("run_err", {29'b0, error, err_code}, 32'd0);
    chk("run_en_cycles", 32'(en_cyc - e0), 32'd4);

    // Invalid opcode at address 4, then restart clears the error
    h0 = halt_cnt; e0 = en_cyc;
    pulse_go(3'd4);
    wait_idle("inv");
    chk("inv_err", {29'b0, error, err_code}, 32'h5);
    chk("inv_no_en", 32'(en_cyc - e0), 32'd0);
    chk("inv_fields", {12'b0, 4'(opcode), a, b}, 32'h7_AA_55);
    chk("inv_no_halt", 32'(halt_cnt - h0), 32'd0);
    pulse_go(3'd0);
    chk("inv_restart_clr", {29'b0, error, err_code}, 32'd0);
    wait_idle("inv_rerun");
    chk("inv_rerun_halt", 32'(halt_cnt - h0), 32'd1);

    // Timeout: done never arrives
    dlat = 0;
    e0 = en_cyc;
    pulse_go(3'd5);
    wait_idle("tmo");
    chk("tmo_en_cycles", 32'(en_cyc - e0), 32'd10);
    chk("tmo_err", {29'b0, error, err_code}, 32'h6);
    chk("tmo_pc", 32'(pc), 32'd5);

    // done on the 10th cycle wins over the timeout
    dlat = 10;
    h0 = halt_cnt; e0 = en_cyc;
    pulse_go(3'd5);
    wait_idle("tmo_edge");
    chk("tmo_edge_en_cycles", 32'(en_cyc - e0), 32'd10);
    chk("tmo_edge_err", {29'b0, error, err_code}, 32'd0);
    chk("tmo_edge_pc", 32'(pc), 32'd6);
    chk("tmo_edge_halt", 32'(halt_cnt - h0), 32'd1);

    // Wrap at the last address
    dlat = 2;
    h0 = halt_cnt;
    pulse_go(3'd7);
    wait_idle("wrap");
    chk("wrap_halt", 32'(halt_cnt - h0), 32'd1);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_err", {31'b0, error}, 32'd0);

    // Reset during EXECUTE
    h0 = halt_cnt;
    pulse_go(3'd1);
    wait_en("rst_mid");
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'b0, mem_rd, enable, busy}, 32'd0);
    chk("rst_mid_pc", 32'(pc), 32'd0);
    chk("rst_mid_fields", {8'b0, 4'(opcode), a, b}, 32'd0);
    repeat (3) tick();
    chk("rst_mid_no_halt", 32'(halt_cnt - h0), 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    // Single step: hold in PAUSE until a step pulse
    step = 1'b0;
    h0 = halt_cnt;
    pulse_go(3'd0);
    wait_en("step");
    begin
      int n = 0;
      while (enable && n < 50) begin
        tick();
        n++;
      end
    end
    r0 = rd_cnt;
    bad = 0;
    repeat (20) begin
      tick();
      if (!busy || enable || mem_rd) bad++;
    end
    chk("step_pause_hold", 32'(bad), 32'd0);
    chk("step_pause_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("step_pause_pc", 32'(pc), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_fetch", {31'b0, mem_rd}, 32'd1);
    begin
      int n = 0;
      while (busy && n < 100) begin
        if (!enable && !mem_rd) step = 1'b1;
        tick();
        step = 1'b0;
        n++;
      end
    end
    chk("step_idle", {31'b0, busy}, 32'd0);
    tick();
    chk("step_halt", 32'(halt_cnt - h0), 32'd1);
    chk("step_pc", 32'(pc), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
